uart_rx: RTL

Serial UART receiver, the downstream counterpart of the team's UART transmitter; same frame format and same parameter set.
- Frame: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Samples the asynchronous rx line at mid-bit and deframes it into bytes.
- Delivers each byte on a valid/ready output with parity-error, framing-error and overrun status.
- Sits between the board rx pin and the consuming logic (FIFO or command parser).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and baud helper.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input that idles high.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling deframer with optional parity and a valid/ready byte output.
// Output handshake: o_vld and its payload hold steady until a cycle with o_vld=1 and i_rdy=1.
module uart_rx
  import uart_pkg::*;
#(
  parameter string PARITY_CHECK = "NONE",
  parameter int    CLK_FREQ     = 50000000,
  parameter int    RX_FREQ      = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       i_rdy,
  output logic       o_vld,
  output logic [7:0] o_data,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic [2:0] dbg_state
);

  localparam int BIT_CYC = bit_cycles(CLK_FREQ, RX_FREQ);
  localparam int CW      = $clog2(BIT_CYC);
  localparam bit PAR_EN  = (PARITY_CHECK != "NONE");
  localparam bit PAR_ODD = (PARITY_CHECK == "ODD");
  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYC / 2 - 1);

  if (PARITY_CHECK != "NONE" && PARITY_CHECK != "ODD" && PARITY_CHECK != "EVEN") begin : g_bad_parity
    $fatal(1, "uart_rx: PARITY_CHECK must be NONE, ODD or EVEN");
  end
  if (BIT_CYC < 4) begin : g_bad_baud
    $fatal(1, "uart_rx: CLK_FREQ/RX_FREQ must be at least 4");
  end

  rx_state_t       state, state_n;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_idx;
  logic [7:0]      shreg;
  logic            par_err;
  logic            tick;
  logic            load_half, load_full, shift_en, par_en, frame_start, complete;

  uart_sync2 u_sync (
    .clk  (clk),
    .rst_n(rst),
    .d    (rx),
    .q    (rx_s)
  );

  assign tick      = (cnt == '0);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!rx_s) state_n = START;
      START:   if (tick) state_n = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_idx == 4'(DATA_BITS - 1)) state_n = PAR_EN ? PARITY : STOP;
      PARITY:  if (tick) state_n = STOP;
      // Leaving at mid-stop-bit leaves half a bit of slack for the next start edge.
      STOP:    if (tick) state_n = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    load_half   = 1'b0;
    load_full   = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    frame_start = 1'b0;
    complete    = 1'b0;
    unique case (state)
      IDLE:   load_half = !rx_s;
      START: begin
        frame_start = tick && !rx_s;
        load_full   = tick && !rx_s;
      end
      DATA: begin
        shift_en  = tick;
        load_full = tick;
      end
      PARITY: begin
        par_en    = tick;
        load_full = tick;
      end
      STOP:    complete = tick;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
    end else begin
      if (load_half)      cnt <= CNT_HALF;
      else if (load_full) cnt <= CNT_FULL;
      else if (!tick)     cnt <= cnt - 1'b1;

      if (frame_start) begin
        bit_idx <= '0;
        par_err <= 1'b0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 4'd1;
        shreg   <= {rx_s, shreg[7:1]};
      end else if (par_en && PAR_EN) begin
        par_err <= PAR_ODD ? (rx_s != ~^shreg) : (rx_s != ^shreg);
      end
    end
  end

  // A frame completing while the previous byte is still unaccepted is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_vld        <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= complete && o_vld && !i_rdy;
      if (complete && (!o_vld || i_rdy)) begin
        o_vld        <= 1'b1;
        o_data       <= shreg;
        o_parity_err <= par_err;
        o_frame_err  <= ~rx_s;
      end else if (o_vld && i_rdy) begin
        o_vld <= 1'b0;
      end
    end
  end

endmodule
